usb_tx_scheduler: RTL and testbench
===================================

Name: usb_tx_scheduler

Overview:
- Shares the single USB byte-write path (write_request / write_data into the FT232H USB block) among NUM_REQ independent byte sources.
- Round-robin grant per burst; a grant holds until end of burst, burst limit, or source drop-out.
- Enforces a minimum spacing between write_request pulses so the FT232H interface is never overrun.
- Sits between producer blocks (switch sampler, status reporters, loopback echo) and the USB block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max bytes per grant before forced re-arbitration (1..255)
MIN_GAP, 4, idle cycles forced after each issued byte before the next accept (0..255)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  in  NUM_REQ  marks the current byte as final of its burst
req_ready  out  NUM_REQ  per-requester accept; transfer = valid & ready on a clock edge
usb_tx_ready  in  1  USB block can take a byte; tie high if unused
write_request  out  1  single-cycle pulse to USB block
write_data  out  8  byte to USB block, stable from pulse until next transfer
grant_id  out  clog2(NUM_REQ)  currently/last granted requester
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, takes priority over everything): state=IDLE, write_request=0, write_data=0, req_ready=0, grant_id=0, busy=0, burst_cnt=0, gap_cnt=0, last_grant=NUM_REQ-1 so requester 0 wins the first arbitration.
- Reset asserted mid-burst: burst abandoned, no pending pulse emitted, pointer restored to reset value.
- States: IDLE, SEND, GAP.
- IDLE, any req_valid high:
  - Select the first valid index searching last_grant+1, last_grant+2, ... with wrap modulo NUM_REQ.
  - Register the selection into grant_id, clear burst_cnt, move to SEND.
  - Arbitration latency is one cycle, and no byte is accepted in this cycle.
- IDLE, no req_valid high: stay in IDLE.
- SEND, req_ready:
  - req_ready[grant_id] = usb_tx_ready, combinational in SEND only.
  - All other req_ready bits are 0 at all times.
- SEND, transfer (valid & ready):
  - Next cycle: write_data = req_data[grant_id], write_request = 1 for exactly one cycle, burst_cnt incremented.
- SEND, after a transfer, next state:
  - Burst ends when req_last was set, or when burst_cnt reaches MAX_BURST on this transfer. Then last_grant = grant_id and the next state is GAP if MIN_GAP > 0, else IDLE.
  - Otherwise the next state is GAP if MIN_GAP > 0, else SEND.
- SEND, req_valid[grant_id] low: release the grant (last_grant = grant_id), go to IDLE. A source dropping valid therefore ends its burst.
- SEND, valid high but usb_tx_ready low: hold in SEND with no timeout.
- GAP:
  - gap_cnt loads MIN_GAP on entry and decrements each cycle. req_ready is all 0.
  - At gap_cnt = 1, go to SEND if the burst continues, else IDLE.
  - GAP lasts exactly MIN_GAP cycles.
- Byte spacing: minimum write_request spacing = MIN_GAP+1 cycles within a burst. Across bursts it is MIN_GAP+2 (includes the arbitration cycle).
- grant_id holds its last value in IDLE.
- busy = (state != IDLE).
- Width rules:
  - burst_cnt is 8 bits and saturates at MAX_BURST; no wrap is possible.
  - The round-robin pointer wraps NUM_REQ-1 -> 0.
- req_last with MAX_BURST=1: every byte ends the burst, with identical behaviour either way.

Decomposition:
- Shared package usb_pkg: byte width constant (8), state enumeration (IDLE/SEND/GAP), clog2 helper.
- One natural sub-module, usb_rr_pick:
  - Combinational round-robin picker: inputs req_valid and last_grant; outputs any_valid and pick index.
  - Parameterised by NUM_REQ; reusable by a future RX dispatcher.

Test Plan:
1. Reset, then only requester 2 valid with bytes 0x11,0x22,0x33 (last on 0x33), MIN_GAP=4 -> grant_id=2, three write_request pulses spaced 5 cycles, write_data 0x11/0x22/0x33, IDLE afterwards, busy low.
2. All four requesters continuously valid, each burst of 2 bytes with req_last -> grant order 0,1,2,3,0; no requester receives two consecutive bursts.
3. Requester 1 streams 40 bytes without req_last, MAX_BURST=16, requester 3 also valid -> 16 bytes from 1, then 16 from 3, then 1 resumes; pulse count per grant is exactly 16.
4. usb_tx_ready held low 20 cycles during SEND with valid high -> req_ready low, no write_request; the byte is accepted on the first cycle usb_tx_ready returns high.
5. Assert reset for one cycle immediately after an accept, before the pulse -> no write_request is emitted, all outputs 0, and the next arbitration grants requester 0.
6. MIN_GAP=0, single requester, 5-byte burst -> write_request high on 5 consecutive cycles, one arbitration cycle before the first byte.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB byte-path blocks: byte width, scheduler
// state encoding and a constant-evaluable ceil(log2) helper.
package usb_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StSend = 2'd1;
    localparam state_t StGap  = 2'd2;

    // Index width for n items; never below one bit so single-entry users still get a port.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: returns the first valid requester after
// last_grant_i, wrapping modulo NUM_REQ. last_grant_i itself has lowest priority.
module usb_rr_pick
    import usb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic               any_valid_o,
    output logic [ID_W-1:0]    pick_o
);

    // Scan from the farthest offset down so the nearest valid index wins last.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx         = '0;
        pick_o      = '0;
        any_valid_o = |req_valid_i;
        for (int off = int'(NUM_REQ); off >= 1; off--) begin
            idx = ID_W'((int'(last_grant_i) + off) % int'(NUM_REQ));
            if (req_valid_i[idx]) begin
                pick_o = idx;
            end
        end
    end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Shares the single USB byte-write path among NUM_REQ byte sources.
// Round-robin grant per burst, burst length cap, and a forced idle gap after
// every issued byte so the downstream FT232H block is never overrun.
module usb_tx_scheduler
    import usb_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned MAX_BURST = 16,
    parameter  int unsigned MIN_GAP   = 4,
    localparam int unsigned ID_W      = clog2(NUM_REQ)
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      usb_tx_ready,
    output logic                      write_request,
    output logic [BYTE_W-1:0]         write_data,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    localparam logic [7:0]      MaxBurst = 8'(MAX_BURST);
    localparam logic [7:0]      MinGap   = 8'(MIN_GAP);
    localparam logic [ID_W-1:0] LastIdx  = ID_W'(NUM_REQ - 1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [7:0]          burst_cnt_q, burst_cnt_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic                cont_q, cont_d;        // burst continues after the current gap
    logic                wr_req_q, wr_req_d;
    logic [BYTE_W-1:0]   wr_data_q, wr_data_d;

    logic                any_valid;
    logic [ID_W-1:0]     pick;
    logic                cur_valid;
    logic                cur_last;
    logic [BYTE_W-1:0]   cur_data;
    logic [7:0]          cnt_inc;
    logic                burst_end;

    usb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .any_valid_o  (any_valid),
        .pick_o       (pick)
    );

    // Select the granted requester's byte lane.
    always_comb begin
        cur_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q == ID_W'(i)) begin
                cur_data = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state logic for arbitration, byte issue and inter-byte gap.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        cont_d       = cont_q;
        wr_req_d     = 1'b0;
        wr_data_d    = wr_data_q;
        req_ready    = '0;

        cur_valid = req_valid[grant_q];
        cur_last  = req_last[grant_q];
        cnt_inc   = (burst_cnt_q < MaxBurst) ? burst_cnt_q + 8'd1 : burst_cnt_q;
        burst_end = cur_last || (cnt_inc >= MaxBurst);

        unique case (state_q)
            StIdle: begin
                // Arbitration cycle: no byte is accepted here.
                if (any_valid) begin
                    grant_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                req_ready[grant_q] = usb_tx_ready;
                if (!cur_valid) begin
                    // Source dropped out: its burst is over.
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end else if (usb_tx_ready) begin
                    wr_req_d    = 1'b1;
                    wr_data_d   = cur_data;
                    burst_cnt_d = cnt_inc;
                    cont_d      = !burst_end;
                    if (burst_end) begin
                        last_grant_d = grant_q;
                    end
                    if (MIN_GAP > 0) begin
                        state_d   = StGap;
                        gap_cnt_d = MinGap;
                    end else begin
                        state_d = burst_end ? StIdle : StSend;
                    end
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q <= 8'd1) begin
                    state_d = cont_q ? StSend : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; synchronous reset abandons any burst and pending pulse.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= LastIdx;
            burst_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            cont_q       <= 1'b0;
            wr_req_q     <= 1'b0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            cont_q       <= cont_d;
            wr_req_q     <= wr_req_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign write_request = wr_req_q;
    assign write_data    = wr_data_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler: two instances (MIN_GAP=4 and MIN_GAP=0)
// fed from scripted byte sources; write_request pulses are logged at negedge.
module tb_usb_tx_scheduler;

    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              usb_tx_ready;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     rdy_a, rdy_b;
    logic              wr_a, wr_b;
    logic [7:0]        wd_a, wd_b;
    logic [1:0]        gid_a, gid_b;
    logic              busy_a, busy_b;
    logic              sel;

    usb_tx_scheduler #(.NUM_REQ(NR), .MAX_BURST(16), .MIN_GAP(4)) dut_a (
        .CLOCK_50      (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (rdy_a),
        .usb_tx_ready  (usb_tx_ready),
        .write_request (wr_a),
        .write_data    (wd_a),
        .grant_id      (gid_a),
        .busy          (busy_a)
    );

    usb_tx_scheduler #(.NUM_REQ(NR), .MAX_BURST(16), .MIN_GAP(0)) dut_b (
        .CLOCK_50      (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (rdy_b),
        .usb_tx_ready  (usb_tx_ready),
        .write_request (wr_b),
        .write_data    (wd_b),
        .grant_id      (gid_b),
        .busy          (busy_b)
    );

    // Scripted sources
    logic [7:0] mem [NR][64];
    int         src_len  [NR];
    int         src_blen [NR];
    int         src_idx  [NR];
    logic       src_rst;

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = (src_idx[i] < src_len[i]);
            req_last[i]        = (src_blen[i] != 0) && (((src_idx[i] + 1) % src_blen[i]) == 0);
            req_data[i*8 +: 8] = mem[i][src_idx[i][5:0]];
        end
    end

    logic [NR-1:0] rdy_m;
    logic          wr_m;
    logic [7:0]    wd_m;
    logic [1:0]    gid_m;
    assign rdy_m = sel ? rdy_b : rdy_a;
    assign wr_m  = sel ? wr_b : wr_a;
    assign wd_m  = sel ? wd_b : wd_a;
    assign gid_m = sel ? gid_b : gid_a;

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (src_rst) src_idx[i] <= 0;
            else if (req_valid[i] && rdy_m[i]) src_idx[i] <= src_idx[i] + 1;
        end
    end

    // Cycle counter and pulse log
    int         cyc = 0;
    int         n_pl = 0;
    logic [7:0] pl_data [512];
    int         pl_gid  [512];
    int         pl_cyc  [512];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_m && n_pl < 512) begin
            pl_data[n_pl] <= wd_m;
            pl_gid[n_pl]  <= int'(gid_m);
            pl_cyc[n_pl]  <= cyc;
            n_pl          <= n_pl + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        src_rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            src_len[i]  = 0;
            src_blen[i] = 0;
        end
        step(2);
        reset   = 1'b0;
        src_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  base, c0, bad, k, b, idx, rq, found;
        reset        = 1'b1;
        usb_tx_ready = 1'b1;
        sel          = 1'b0;
        src_rst      = 1'b1;
        for (int i = 0; i < NR; i++) begin
            src_len[i]  = 0;
            src_blen[i] = 0;
            for (int j = 0; j < 64; j++) mem[i][j] = 8'(i * 64 + j + 1);
        end
        step(3);

        // Reset state
        chk("rst_wr",    32'(wr_a),   32'd0);
        chk("rst_wd",    32'(wd_a),   32'd0);
        chk("rst_ready", 32'(rdy_a),  32'd0);
        chk("rst_gid",   32'(gid_a),  32'd0);
        chk("rst_busy",  32'(busy_a), 32'd0);

        // 1: lone requester 2, three bytes, spacing MIN_GAP+1
        do_reset();
        mem[2][0] = 8'h11; mem[2][1] = 8'h22; mem[2][2] = 8'h33;
        base = n_pl; c0 = cyc;
        src_len[2] = 3; src_blen[2] = 3;
        step(25);
        chk("t1_count", 32'(n_pl - base), 32'd3);
        chk("t1_lat",   32'(pl_cyc[base] - c0), 32'd2);
        chk("t1_d0",    32'(pl_data[base]),     32'h11);
        chk("t1_d1",    32'(pl_data[base + 1]), 32'h22);
        chk("t1_d2",    32'(pl_data[base + 2]), 32'h33);
        chk("t1_g0",    32'(pl_gid[base]),      32'd2);
        chk("t1_sp1",   32'(pl_cyc[base + 1] - pl_cyc[base]),     32'd5);
        chk("t1_sp2",   32'(pl_cyc[base + 2] - pl_cyc[base + 1]), 32'd5);
        chk("t1_busy",  32'(busy_a), 32'd0);
        chk("t1_gid",   32'(gid_a),  32'd2);
        for (int j = 0; j < 3; j++) mem[2][j] = 8'(2 * 64 + j + 1);

        // 2: all four valid, 2-byte bursts -> grants 0,1,2,3,0
        do_reset();
        base = n_pl;
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 10; src_blen[i] = 2;
        end
        step(60);
        chk("t2_count", 32'(n_pl - base >= 10), 32'd1);
        for (k = 0; k < 10; k++) begin
            b   = k / 2;
            rq  = b % 4;
            idx = (b / 4) * 2 + (k % 2);
            chk($sformatf("t2_gid%0d", k),  32'(pl_gid[base + k]),  32'(rq));
            chk($sformatf("t2_data%0d", k), 32'(pl_data[base + k]), 32'(rq * 64 + idx + 1));
        end
        chk("t2_sp_in",  32'(pl_cyc[base + 1] - pl_cyc[base]),     32'd5);
        chk("t2_sp_out", 32'(pl_cyc[base + 2] - pl_cyc[base + 1]), 32'd6);

        // 3: requesters 1 and 3 stream without last; MAX_BURST caps each grant at 16
        do_reset();
        base = n_pl;
        src_len[1] = 40; src_len[3] = 40;
        step(175);
        chk("t3_count", 32'(n_pl - base >= 33), 32'd1);
        for (k = 0; k < 33; k++) begin
            if (k < 16)      begin rq = 1; idx = k;      end
            else if (k < 32) begin rq = 3; idx = k - 16; end
            else             begin rq = 1; idx = 16;     end
            chk($sformatf("t3_gid%0d", k),  32'(pl_gid[base + k]),  32'(rq));
            chk($sformatf("t3_data%0d", k), 32'(pl_data[base + k]), 32'(rq * 64 + idx + 1));
        end
        chk("t3_sp_rearb", 32'(pl_cyc[base + 16] - pl_cyc[base + 15]), 32'd6);

        // 4: usb_tx_ready low for 20 cycles while in SEND
        do_reset();
        usb_tx_ready = 1'b0;
        base = n_pl;
        src_len[0] = 2; src_blen[0] = 2;
        step(1);
        chk("t4_busy",  32'(busy_a), 32'd1);
        chk("t4_rdy0",  32'(rdy_a),  32'd0);
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            step(1);
            if (rdy_a != 4'd0 || wr_a !== 1'b0) bad++;
        end
        chk("t4_stall_bad", 32'(bad), 32'd0);
        chk("t4_no_pulse",  32'(n_pl - base), 32'd0);
        usb_tx_ready = 1'b1;
        #1;
        chk("t4_rdy_back", 32'(rdy_a), 32'b0001);
        step(1);
        chk("t4_wr",  32'(wr_a), 32'd1);
        chk("t4_wd",  32'(wd_a), 32'd1);

        // 5: reset on the accept edge -> no pulse, pointer restored
        do_reset();
        src_len[0] = 1; src_blen[0] = 1;
        src_len[1] = 5;
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            step(1);
            if (busy_a && gid_a == 2'd1 && rdy_a[1]) found = 1;
        end
        chk("t5_reach", 32'(found), 32'd1);
        base  = n_pl;
        reset = 1'b1;
        src_len[0] = 2;
        step(1);
        chk("t5_wr",    32'(wr_a),   32'd0);
        chk("t5_wd",    32'(wd_a),   32'd0);
        chk("t5_rdy",   32'(rdy_a),  32'd0);
        chk("t5_gid",   32'(gid_a),  32'd0);
        chk("t5_busy",  32'(busy_a), 32'd0);
        reset = 1'b0;
        step(1);
        chk("t5_regid",  32'(gid_a),  32'd0);
        chk("t5_rebusy", 32'(busy_a), 32'd1);
        chk("t5_nopulse", 32'(n_pl - base), 32'd0);

        // 6: MIN_GAP=0 instance, 5-byte burst on consecutive cycles
        sel = 1'b1;
        do_reset();
        base = n_pl; c0 = cyc;
        src_len[0] = 5; src_blen[0] = 5;
        step(15);
        chk("t6_count", 32'(n_pl - base), 32'd5);
        for (k = 0; k < 5; k++) begin
            chk($sformatf("t6_cyc%0d", k),  32'(pl_cyc[base + k] - c0), 32'(2 + k));
            chk($sformatf("t6_data%0d", k), 32'(pl_data[base + k]),     32'(k + 1));
        end
        chk("t6_busy", 32'(busy_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
